line_buffer_3row: RTL

Streaming line buffer that sits between the pixel source and the Sobel kernel. It stores the two previous image rows in two `sync_ram_block` instances, each one line deep. For every accepted pixel it emits a vertical 3-pixel column (top, mid, bottom), which the kernel shifts horizontally into its 3x3 window. Input and output both use valid/ready handshakes, and the block sustains one pixel per cycle with a 2-entry output buffer absorbing backpressure.

---
 rtl/line_buffer_3row_if.sv | 29 ++
 rtl/line_buffer_3row.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_3row_if.sv
// Pixel-in / column-out stream bundle for line_buffer_3row.
// Both directions use valid/ready: a beat moves on a rising edge where valid and ready are both high.
// The producer holds valid and its payload until the beat moves. Ready may change at any time.
interface line_buffer_3row_if #(
    parameter int WIDTH_P = 8
) ();
    logic               valid_i;
    logic               ready_o;
    logic [WIDTH_P-1:0] data_i;
    logic               sof_i;
    logic               valid_o;
    logic               ready_i;
    logic [WIDTH_P-1:0] top_o;
    logic [WIDTH_P-1:0] mid_o;
    logic [WIDTH_P-1:0] bot_o;
    logic               eol_o;

    // The line buffer itself.
    modport slave (
        input  valid_i, data_i, sof_i, ready_i,
        output ready_o, valid_o, top_o, mid_o, bot_o, eol_o
    );

    // The pixel source and the kernel, as seen from outside.
    modport master (
        output valid_i, data_i, sof_i, ready_i,
        input  ready_o, valid_o, top_o, mid_o, bot_o, eol_o
    );
endinterface

// File: rtl/line_buffer_3row.sv
// Three-row line buffer feeding a 3x3 kernel: two one-line RAMs hold rows r-1 and r-2, one column per pixel.
// Optional build macro LINE_BUFFER_EDGE_EN: emit every row, zero-padding the missing rows above.

module sync_ram_block #(
    parameter int WIDTH_P  = 8,
    parameter int DEPTH_P  = 16,
    parameter int ADDR_W_P = 4
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [ADDR_W_P-1:0] waddr_i,
    input  logic [WIDTH_P-1:0]  wdata_i,
    input  logic [ADDR_W_P-1:0] raddr_i,
    output logic [WIDTH_P-1:0]  rdata_o
);
    logic [WIDTH_P-1:0] mem_q [DEPTH_P];

    // A read and a write to the same address on one edge return the old word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end
endmodule

module line_buffer_3row #(
    parameter int WIDTH_P      = 8,
    parameter int LINE_WIDTH_P = 16
) (
    input logic               clk_i,
    input logic               rstn_i,
    line_buffer_3row_if.slave bus
);
    localparam int CW = (LINE_WIDTH_P > 1) ? $clog2(LINE_WIDTH_P) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(LINE_WIDTH_P - 1);

    typedef struct packed {
        logic [WIDTH_P-1:0] top;
        logic [WIDTH_P-1:0] mid;
        logic [WIDTH_P-1:0] bot;
        logic               eol;
    } column_t;

    // Position counters.
    logic [CW-1:0] col_q, col_d, eff_col;
    logic [1:0]    row_q, row_d, eff_row;
    logic          at_eol, emit, accept, ready;

    // Pending stage: the pixel accepted on the previous edge, waiting for its RAM reads.
    logic               p_q;
    logic [WIDTH_P-1:0] pend_data_q;
    logic [CW-1:0]      pend_col_q;
    logic               pend_eol_q;
    logic               pend_emit_q;
`ifdef LINE_BUFFER_EDGE_EN
    logic [1:0]         pend_row_q;
`endif

    // RAM ports.
    logic [WIDTH_P-1:0] a_rdata, b_rdata;

    // Output buffer.
    column_t    fifo_q [2];
    column_t    push_col, head;
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] occ_q;
    logic       push, pop;
    logic [2:0] level;

    // sof restarts the frame on the pixel that carries it, even when it lands mid-line.
    always_comb begin
        eff_col = bus.sof_i ? '0 : col_q;
        eff_row = bus.sof_i ? 2'd0 : row_q;
        at_eol  = (eff_col == LAST_COL);
        col_d   = at_eol ? '0 : eff_col + CW'(1);
        row_d   = (at_eol && (eff_row != 2'd2)) ? eff_row + 2'd1 : eff_row;
`ifdef LINE_BUFFER_EDGE_EN
        emit    = 1'b1;
`else
        emit    = (eff_row == 2'd2);
`endif
    end

    assign accept = bus.valid_i && ready;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            col_q <= '0;
            row_q <= 2'd0;
        end else if (accept) begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            p_q         <= 1'b0;
            pend_data_q <= '0;
            pend_col_q  <= '0;
            pend_eol_q  <= 1'b0;
            pend_emit_q <= 1'b0;
`ifdef LINE_BUFFER_EDGE_EN
            pend_row_q  <= 2'd0;
`endif
        end else begin
            p_q <= accept;
            if (accept) begin
                pend_data_q <= bus.data_i;
                pend_col_q  <= eff_col;
                pend_eol_q  <= at_eol;
                pend_emit_q <= emit;
`ifdef LINE_BUFFER_EDGE_EN
                pend_row_q  <= eff_row;
`endif
            end
        end
    end

    // RAM A takes the new pixel at once; the old A word moves into B one cycle later.
    // B is written at the pending column while the next pixel reads the following column.
    sync_ram_block #(
        .WIDTH_P  (WIDTH_P),
        .DEPTH_P  (LINE_WIDTH_P),
        .ADDR_W_P (CW)
    ) u_ram_a (
        .clk_i   (clk_i),
        .we_i    (accept),
        .waddr_i (eff_col),
        .wdata_i (bus.data_i),
        .raddr_i (eff_col),
        .rdata_o (a_rdata)
    );

    sync_ram_block #(
        .WIDTH_P  (WIDTH_P),
        .DEPTH_P  (LINE_WIDTH_P),
        .ADDR_W_P (CW)
    ) u_ram_b (
        .clk_i   (clk_i),
        .we_i    (p_q),
        .waddr_i (pend_col_q),
        .wdata_i (a_rdata),
        .raddr_i (eff_col),
        .rdata_o (b_rdata)
    );

    always_comb begin
        push_col.top = b_rdata;
        push_col.mid = a_rdata;
        push_col.bot = pend_data_q;
        push_col.eol = pend_eol_q;
`ifdef LINE_BUFFER_EDGE_EN
        if (pend_row_q != 2'd2) begin
            push_col.top = '0;
        end
        if (pend_row_q == 2'd0) begin
            push_col.mid = '0;
        end
`endif
    end

    assign push = p_q && pend_emit_q;
    assign pop  = (occ_q != 2'd0) && bus.ready_i;

    // Count the in-flight pixel as occupied so its column always has a slot.
    assign level = 3'(occ_q) + 3'(p_q) - 3'(pop);
    assign ready = (level < 3'd2);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= push_col;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + 2'(push) - 2'(pop);
        end
    end

    assign head        = fifo_q[rd_ptr_q];
    assign bus.ready_o = ready;
    assign bus.valid_o = (occ_q != 2'd0);
    assign bus.top_o   = head.top;
    assign bus.mid_o   = head.mid;
    assign bus.bot_o   = head.bot;
    assign bus.eol_o   = head.eol;
endmodule
